approx_mult_arb: RTL

APPROX_MULT_ARB -- requirements
Module: approx_mult_arb

---
 rtl/mult_arb_pkg.sv | 22 ++
 rtl/approx_22x16_signed.sv | 21 ++
 rtl/approx_mult_arb_rr_arbiter.sv | 31 +++
 rtl/approx_mult_arb.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/mult_arb_pkg.sv
// Shared widths, FSM encoding and request bundle for the arbitrated
// approximate multiplier.
package mult_arb_pkg;

    localparam int OP_A_W      = 16;
    localparam int OP_B_W      = 22;
    localparam int PROD_W      = 38;
    // Low multiplicand bits ignored by the approximate datapath.
    localparam int APPROX_DROP = 8;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    typedef struct packed {
        logic signed [OP_A_W-1:0] a;
        logic signed [OP_B_W-1:0] b;
        logic                     precise;
    } mult_req_t;

endpackage

// File: rtl/approx_22x16_signed.sv
// Combinational 22x16 signed multiplier; approximate mode clears the low
// APPROX_DROP multiplicand bits before multiplying.
module approx_22x16_signed
    import mult_arb_pkg::*;
(
    input  logic signed [OP_A_W-1:0] a,
    input  logic signed [OP_B_W-1:0] b,
    input  logic                     precise_en,
    output logic signed [PROD_W-1:0] product
);

    logic signed [OP_B_W-1:0] b_trunc_s;
    logic signed [PROD_W-1:0] exact_s;
    logic signed [PROD_W-1:0] approx_s;

    assign b_trunc_s = {b[OP_B_W-1:APPROX_DROP], {APPROX_DROP{1'b0}}};
    assign exact_s   = a * b;
    assign approx_s  = a * b_trunc_s;
    assign product   = precise_en ? exact_s : approx_s;

endmodule

// File: rtl/approx_mult_arb_rr_arbiter.sv
// Round-robin grant: first valid requester at or after ptr wins, and
// nothing is granted unless advance is high.
module rr_arbiter #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    input  logic            advance,
    output logic [N-1:0]    grant
);

    int   idx_s;
    logic found_s;
    logic hit_s;

    // Scan requesters in rotated order and keep the first hit.
    always_comb begin
        grant   = {N{1'b0}};
        found_s = 1'b0;
        hit_s   = 1'b0;
        idx_s   = 0;
        for (int k = 0; k < N; k++) begin
            idx_s        = (int'(ptr) + k) % N;
            hit_s        = !found_s && req[idx_s] && advance;
            grant[idx_s] = hit_s;
            found_s      = found_s | hit_s;
        end
    end

endmodule

// File: rtl/approx_mult_arb.sv
// NUM_REQ requesters share one approximate multiplier through a round-robin
// arbiter; the product is registered in a single-entry result buffer.
module approx_mult_arb
    import mult_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int CNT_W   = 16,
    localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ-1:0][OP_A_W-1:0] req_a,
    input  logic [NUM_REQ-1:0][OP_B_W-1:0] req_b,
    input  logic [NUM_REQ-1:0]             req_precise,
    input  logic                           force_precise,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [ID_W-1:0]                rsp_id,
    output logic [PROD_W-1:0]              rsp_product,
    output logic                           rsp_precise,
    input  logic                           clr_stats,
    output logic [CNT_W-1:0]               cnt_precise,
    output logic [CNT_W-1:0]               cnt_approx
);

    state_t            state_r;
    state_t            next_state_s;
    logic [ID_W-1:0]   ptr_r;
    logic [ID_W-1:0]   next_ptr_s;
    logic [ID_W-1:0]   grant_idx_s;
    logic [NUM_REQ-1:0] grant_s;
    logic              can_accept_s;
    logic              req_hs_s;
    logic              rsp_hs_s;
    logic              issue_precise_s;
    mult_req_t         sel_req_s;
    logic [PROD_W-1:0] product_s;
    logic [ID_W-1:0]   rsp_id_r;
    logic [PROD_W-1:0] rsp_product_r;
    logic              rsp_precise_r;
    logic [CNT_W-1:0]  cnt_precise_r;
    logic [CNT_W-1:0]  cnt_approx_r;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // rst_n gates acceptance so req_ready is low for the whole reset.
    assign can_accept_s    = rst_n & ((state_r == EMPTY) | rsp_ready);
    assign req_ready       = grant_s;
    assign req_hs_s        = |(req_valid & grant_s);
    assign rsp_hs_s        = rsp_valid & rsp_ready;
    assign issue_precise_s = sel_req_s.precise | force_precise;
    assign rsp_valid       = (state_r == FULL);
    assign rsp_id          = rsp_id_r;
    assign rsp_product     = rsp_product_r;
    assign rsp_precise     = rsp_precise_r;
    assign cnt_precise     = cnt_precise_r;
    assign cnt_approx      = cnt_approx_r;

    rr_arbiter #(
        .N    (NUM_REQ),
        .ID_W (ID_W)
    ) u_arb (
        .req     (req_valid),
        .ptr     (ptr_r),
        .advance (can_accept_s),
        .grant   (grant_s)
    );

    // One-hot AND-OR mux of the granted requester's operands and index.
    always_comb begin
        grant_idx_s = {ID_W{1'b0}};
        sel_req_s   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_idx_s       = grant_idx_s | (grant_s[i] ? ID_W'(i) : {ID_W{1'b0}});
            sel_req_s.a       = sel_req_s.a | (req_a[i] & {OP_A_W{grant_s[i]}});
            sel_req_s.b       = sel_req_s.b | (req_b[i] & {OP_B_W{grant_s[i]}});
            sel_req_s.precise = sel_req_s.precise | (req_precise[i] & grant_s[i]);
        end
    end

    // Pointer moves to the slot just after the winner.
    always_comb begin
        if (grant_idx_s == ID_W'(NUM_REQ - 1)) begin
            next_ptr_s = {ID_W{1'b0}};
        end else begin
            next_ptr_s = grant_idx_s + {{(ID_W-1){1'b0}}, 1'b1};
        end
    end

    approx_22x16_signed u_mult (
        .a          (sel_req_s.a),
        .b          (sel_req_s.b),
        .precise_en (issue_precise_s),
        .product    (product_s)
    );

    // Result-buffer occupancy: a new issue always wins over draining.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            EMPTY: begin
                if (req_hs_s) begin
                    next_state_s = FULL;
                end else begin
                    next_state_s = EMPTY;
                end
            end
            FULL: begin
                if (req_hs_s) begin
                    next_state_s = FULL;
                end else if (rsp_ready) begin
                    next_state_s = EMPTY;
                end else begin
                    next_state_s = FULL;
                end
            end
            default: next_state_s = EMPTY;
        endcase
    end

    // State, pointer and result register; only loaded on an issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= EMPTY;
            ptr_r         <= {ID_W{1'b0}};
            rsp_id_r      <= {ID_W{1'b0}};
            rsp_product_r <= {PROD_W{1'b0}};
            rsp_precise_r <= 1'b0;
        end else begin
            state_r <= next_state_s;
            if (req_hs_s) begin
                ptr_r         <= next_ptr_s;
                rsp_id_r      <= grant_idx_s;
                rsp_product_r <= product_s;
                rsp_precise_r <= issue_precise_s;
            end
        end
    end

    // Saturating completion counters; clear beats increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_precise_r <= {CNT_W{1'b0}};
            cnt_approx_r  <= {CNT_W{1'b0}};
        end else if (clr_stats) begin
            cnt_precise_r <= {CNT_W{1'b0}};
            cnt_approx_r  <= {CNT_W{1'b0}};
        end else if (rsp_hs_s) begin
            if (rsp_precise_r) begin
                cnt_precise_r <= sat_inc(cnt_precise_r);
            end else begin
                cnt_approx_r <= sat_inc(cnt_approx_r);
            end
        end
    end

endmodule
